// File: rtl/rand_pkg.sv
// Shared definitions for the random point picker and the VGA/game blocks
// that consume its screen coordinates.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PICK_X,
        PICK_Y,
        HOLD
    } state_t;

    localparam int RND_W           = 13;
    localparam int DEF_XW          = 8;
    localparam int DEF_YW          = 7;
    localparam int DEF_LIMIT_X     = 160;
    localparam int DEF_LIMIT_Y     = 120;
    localparam int DEF_MAX_TRIES   = 15;
    localparam int TRY_W           = 4;

    // A bound is usable only if one fold subtraction always lands inside it.
    function automatic bit limit_ok(input int w, input int limit);
        return (limit > (1 << (w - 1))) && (limit <= (1 << w));
    endfunction

endpackage

// File: rtl/rand_point_picker_if.sv
// Request/point handshake between game logic (master) and the picker (slave).
interface rand_point_picker_if #(
    parameter int XW = rand_pkg::DEF_XW,
    parameter int YW = rand_pkg::DEF_YW
) ();
    logic          req_valid;
    logic          req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic          folded;

    modport master (
        output req_valid, out_ready,
        input  req_ready, out_valid, x_out, y_out, folded
    );

    modport slave (
        input  req_valid, out_ready,
        output req_ready, out_valid, x_out, y_out, folded
    );
endinterface

// File: rtl/rand_axis_accept.sv
// Single-axis rejection test: accept an in-range candidate, or on the last
// try fold it back into range by subtracting the bound once.
module rand_axis_accept #(
    parameter int W     = 8,
    parameter int LIMIT = 160
) (
    input  logic [W-1:0] cand,
    input  logic         last_try,
    output logic         accept,
    output logic [W-1:0] value
);
    // One extra bit so LIMIT == 2^W compares correctly.
    localparam logic [W:0] LIMIT_EXT = (W + 1)'(LIMIT);

    logic in_range;

    assign in_range = ({1'b0, cand} < LIMIT_EXT);
    assign accept   = in_range | last_try;
    assign value    = in_range ? cand : (cand - LIMIT_EXT[W-1:0]);
endmodule

// File: rtl/rand_point_picker.sv
// Turns the free-running LFSR stream into a uniform (x, y) point on request
// using bounded rejection sampling, one axis after the other.
module rand_point_picker
    import rand_pkg::*;
#(
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int LIMIT_X   = DEF_LIMIT_X,
    parameter int LIMIT_Y   = DEF_LIMIT_Y,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RND_W-1:0] rnd,
    rand_point_picker_if.slave bus
);

    if (!limit_ok(XW, LIMIT_X)) begin : g_bad_limit_x
        $error("rand_point_picker: LIMIT_X out of range for XW");
    end
    if (!limit_ok(YW, LIMIT_Y)) begin : g_bad_limit_y
        $error("rand_point_picker: LIMIT_Y out of range for YW");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_tries
        $error("rand_point_picker: MAX_TRIES must be 1..15");
    end

    state_t           state_reg, state_next;
    logic [TRY_W-1:0] tries_reg, tries_next;
    logic [XW-1:0]    x_reg, x_next;
    logic [YW-1:0]    y_reg, y_next;
    logic             folded_reg, folded_next;

    logic             last_try;
    logic [XW-1:0]    x_cand, x_value;
    logic [YW-1:0]    y_cand, y_value;
    logic             x_accept, y_accept;
    logic             unused_rnd_bits;

    assign last_try        = (tries_reg == TRY_W'(MAX_TRIES - 1));
    assign x_cand          = rnd[XW-1:0];
    assign y_cand          = rnd[YW-1:0];
    assign unused_rnd_bits = ^rnd[RND_W-1:XW];

    rand_axis_accept #(.W(XW), .LIMIT(LIMIT_X)) u_accept_x (
        .cand     (x_cand),
        .last_try (last_try),
        .accept   (x_accept),
        .value    (x_value)
    );

    rand_axis_accept #(.W(YW), .LIMIT(LIMIT_Y)) u_accept_y (
        .cand     (y_cand),
        .last_try (last_try),
        .accept   (y_accept),
        .value    (y_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            tries_reg  <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            folded_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tries_reg  <= tries_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            folded_reg <= folded_next;
        end
    end

    // A folded sample is the only case where the accepted value differs
    // from the raw candidate (the bound is never a multiple of 2^W here).
    always_comb begin
        state_next  = state_reg;
        tries_next  = tries_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        folded_next = folded_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next  = PICK_X;
                    tries_next  = '0;
                    folded_next = 1'b0;
                end
            end
            PICK_X: begin
                if (x_accept) begin
                    x_next     = x_value;
                    tries_next = '0;
                    state_next = PICK_Y;
                    if (x_value != x_cand) folded_next = 1'b1;
                end else begin
                    tries_next = tries_reg + 1'b1;
                end
            end
            PICK_Y: begin
                if (y_accept) begin
                    y_next     = y_value;
                    tries_next = '0;
                    state_next = HOLD;
                    if (y_value != y_cand) folded_next = 1'b1;
                end else begin
                    tries_next = tries_reg + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.x_out     = x_reg;
    assign bus.y_out     = y_reg;
    assign bus.folded    = folded_reg;

endmodule

// File: doc/rand_point_picker.md
# rand_point_picker

Downstream consumer of the 13-bit LFSR random generator. Converts the free-running `rnd` stream into a uniformly distributed screen coordinate (x in [0, LIMIT_X), y in [0, LIMIT_Y)) on request, using bounded rejection sampling. Game logic uses it for spawn/placement positions, with a valid/ready handshake on both sides.

## Interface
- `XW`, 8, x coordinate width
- `YW`, 7, y coordinate width
- `LIMIT_X`, 160, exclusive x bound; legal range 2^(XW-1) < LIMIT_X ≤ 2^XW
- `LIMIT_Y`, 120, exclusive y bound; legal range 2^(YW-1) < LIMIT_Y ≤ 2^YW
- `MAX_TRIES`, 15, samples per axis before fold fallback; 1..15
- `clock`  in  1  single clock; all state on posedge
- `reset`  in  1  asynchronous, active-high reset
- `rnd`  in  13  LFSR output; new value every clock
- `req_valid`  in  1  request for a new point
- `req_ready`  out  1  block idle and able to accept a request
- `out_valid`  out  1  `x_out`/`y_out` hold a fresh point
- `out_ready`  in  1  consumer accepts the point
- `x_out`  out  XW  x coordinate
- `y_out`  out  YW  y coordinate
- `folded`  out  1  point used fold fallback on at least one axis

## Operation
- States: IDLE, PICK_X, PICK_Y, HOLD. Reset enters IDLE.
- Reset values: `x_out`=0, `y_out`=0, `out_valid`=0, `folded`=0, try counter=0. `req_ready`=1 (decoded from IDLE).
- `req_ready` = (state==IDLE). `out_valid` = (state==HOLD). Both are registered-state decodes with no combinational path from inputs.
- IDLE: on `req_valid`, go to PICK_X, clear try counter and `folded`.
- PICK_X: candidate cx = `rnd[XW-1:0]`.
  - If cx < LIMIT_X: load `x_out`, clear tries, go to PICK_Y.
  - Else if tries == MAX_TRIES-1: load cx − LIMIT_X, set `folded`, clear tries, go to PICK_Y.
  - Else: tries+1 and stay in PICK_X.
- PICK_Y: same rule with cy = `rnd[YW-1:0]`, LIMIT_Y, and `y_out`. Exit goes to HOLD.
- HOLD: outputs stable. On `out_ready`, go to IDLE; `x_out`/`y_out`/`folded` keep their values.
- Fold subtraction is in XW/YW bits. The legal parameter range guarantees the result is < LIMIT. With LIMIT = 2^W, every sample is accepted.
- The LFSR advances every clock, so X and Y always sample distinct `rnd` values.
- `req_valid` outside IDLE is ignored. `out_ready` outside HOLD is ignored.
- Asynchronous reset in any state aborts immediately to reset values. No partial point is ever presented.

## Timing
- Request accepted on edge E0 (IDLE & `req_valid`).
- Best case: x sampled at E1, y at E2, `out_valid`=1 after E2. That is 2 cycles after acceptance.
- Worst case: 2·MAX_TRIES cycles after acceptance (30 with defaults).
- Handshake completes on the edge where HOLD & `out_ready`. `req_ready` rises the following cycle.
- Minimum request-to-request spacing: 4 cycles.

## Structure
- Shared package `rand_pkg` holds:
  - state enum (IDLE, PICK_X, PICK_Y, HOLD)
  - default LIMIT_X/LIMIT_Y/XW/YW constants, shared with the VGA/game blocks
  - try-counter width (4)
- One sub-module, `rand_axis_accept`: combinational, parameterised on W/LIMIT. Inputs are cand and last_try; outputs are accept and value (cand or cand−LIMIT). Instantiated twice, once for x and once for y.
- Elaboration-time check on LIMIT and MAX_TRIES legality.

## Test plan
- `rnd`=13'h0005 constant, pulse `req_valid`, `out_ready`=1 → `out_valid` 2 cycles after acceptance with x=5, y=5, `folded`=0.
- `rnd` sequence 0x0A0, 0x09F, 0x078, 0x077 starting at the first PICK_X cycle → x rejects 160 then accepts 159; y rejects 120 then accepts 119. Output (159,119), latency 4, `folded`=0.
- `rnd`=13'h1FFF constant → 15 rejections per axis, folds to x=95, y=7, `folded`=1, `out_valid` exactly 30 cycles after acceptance.
- `out_ready`=0 for 10 cycles in HOLD → `x_out`/`y_out`/`folded` stable and `req_ready`=0 throughout. Raise `out_ready` → `req_ready`=1 next cycle.
- Assert `reset` mid-PICK_Y, after x was loaded → all outputs return to 0 asynchronously and state returns to IDLE. A new request afterwards completes normally.
- `req_valid` held high continuously with `rnd`=13'h0005 and `out_ready`=1 → back-to-back points every 4 cycles. No request is accepted outside IDLE.
